// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Initiator side of the instruction-memory read interface. Holds the PC, drives
// the combinational instruction memory address from it, and registers the
// returned word into a one-entry fetch buffer toward decode (valid/ready
// handshake). Supports branch/jump redirect, decode backpressure, and halting
// when an all-zero word (the memory's default contents) is fetched.
//
// Ports
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous reset, active low
//   fetch_en       in   1       1 = fetching permitted, 0 = pause
//   imem_addr      out  ADDR_W  instruction memory byte address (= PC)
//   imem_rdata     in   DATA_W  word at imem_addr, same cycle
//   redirect_valid in   1       load redirect_pc into the PC this cycle
//   redirect_pc    in   ADDR_W  redirect target, low two bits ignored
//   inst_valid     out  1       fetch buffer holds an instruction
//   inst           out  DATA_W  buffered instruction word
//   inst_pc        out  ADDR_W  address the buffered word came from
//   inst_ready     in   1       decode accepts inst this cycle
//   halted         out  1       1 while in HALT
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] p);
        return p & ~ADDR_W'(3);
    endfunction

    // Sequential PC step; wraps naturally modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        return p + ADDR_W'(4);
    endfunction

    state_t              state_q;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc_p0;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [DATA_W-1:0]   inst_p1;
    logic [DATA_W-1:0]   inst_nxt;
    logic [ADDR_W-1:0]   inst_pc_p1;
    logic [ADDR_W-1:0]   inst_pc_nxt;
    logic                vld_p1;
    logic                vld_nxt;
    logic                load;
    logic                zero_word;
    logic                handshake;

    assign zero_word = (imem_rdata == '0);
    assign handshake = vld_p1 & inst_ready;
    // A slot is free when the buffer is empty or is being drained this cycle.
    assign load      = (state_q == RUN) & fetch_en & ~redirect_valid
                     & (~vld_p1 | inst_ready);

    // Next-state and fetch-buffer update; redirect outranks everything.
    always_comb begin
        state_nxt   = state_q;
        pc_nxt      = pc_p0;
        inst_nxt    = inst_p1;
        inst_pc_nxt = inst_pc_p1;
        vld_nxt     = vld_p1;

        if (redirect_valid) begin
            // Buffered word is flushed even if decode is taking it this cycle.
            pc_nxt    = align_pc(redirect_pc);
            vld_nxt   = 1'b0;
            state_nxt = RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        state_nxt = RUN;
                    end
                    if (handshake) begin
                        vld_nxt = 1'b0;
                    end
                end
                RUN: begin
                    if (load) begin
                        if (zero_word) begin
                            // PC stays on the zero word so the halt point is visible.
                            vld_nxt   = 1'b0;
                            state_nxt = HALT;
                        end else begin
                            inst_nxt    = imem_rdata;
                            inst_pc_nxt = pc_p0;
                            vld_nxt     = 1'b1;
                            pc_nxt      = pc_inc(pc_p0);
                        end
                    end else if (handshake) begin
                        vld_nxt = 1'b0;
                    end
                end
                HALT: begin
                    if (handshake) begin
                        vld_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stage 0: program counter and control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_p0   <= align_pc(RESET_PC);
        end else begin
            state_q <= state_nxt;
            pc_p0   <= pc_nxt;
        end
    end

    // Stage 1: fetch buffer toward decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            inst_p1    <= '0;
            inst_pc_p1 <= '0;
        end else begin
            vld_p1     <= vld_nxt;
            inst_p1    <= inst_nxt;
            inst_pc_p1 <= inst_pc_nxt;
        end
    end

    assign imem_addr  = pc_p0;
    assign inst_valid = vld_p1;
    assign inst       = inst_p1;
    assign inst_pc    = inst_pc_p1;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              halted;

    logic [DATA_W-1:0] mem [0:63];
    logic [39:0]       exp_q [$];
    int                n_vec = 0;
    int                n_err = 0;

    inst_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .halted         (halted)
    );

    // Combinational instruction memory
    assign imem_rdata = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a);
        exp_q.push_back({a, mem[a[7:2]]});
    endtask

    // Scoreboard consumer: a handshake not flushed by redirect retires one word.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", {56'd0, inst_pc}, 64'hFFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", {56'd0, inst_pc}, {56'd0, e[39:32]});
                chk("sb_inst", {32'd0, inst}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h00100093;
        mem[1] = 32'h0ff00103;
        mem[2] = 32'h001171b3;
        for (int i = 3; i < 11; i++) mem[i] = 32'hA000_0000 | (i << 2);
        // 0x2C (index 11) left zero: halt point
        mem[63] = 32'h5A5A_00FC;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        tick();
        tick();
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_addr", {56'd0, imem_addr}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", {56'd0, inst_pc}, 64'd0);

        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_valid", {63'd0, inst_valid}, 64'd0);
        chk("idle_addr", {56'd0, imem_addr}, 64'd0);

        // Straight-line fetch
        push_exp(8'h00);
        push_exp(8'h04);
        push_exp(8'h08);
        fetch_en = 1'b1;
        tick();
        chk("t1_no_early_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        chk("t1_pc0", {56'd0, inst_pc}, 64'h00);
        chk("t1_inst0", {32'd0, inst}, 64'h00100093);
        tick();
        chk("t1_pc1", {56'd0, inst_pc}, 64'h04);
        tick();
        chk("t1_pc2", {56'd0, inst_pc}, 64'h08);
        chk("t1_inst2", {32'd0, inst}, 64'h001171b3);

        // Backpressure
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", {63'd0, inst_valid}, 64'd1);
            chk("t2_hold_pc", {56'd0, inst_pc}, 64'h08);
            chk("t2_hold_inst", {32'd0, inst}, 64'h001171b3);
            chk("t2_hold_addr", {56'd0, imem_addr}, 64'h0C);
        end
        push_exp(8'h0C);
        inst_ready = 1'b1;
        tick();
        chk("t2_resume_pc", {56'd0, inst_pc}, 64'h0C);
        tick();
        chk("t3_pre_pc", {56'd0, inst_pc}, 64'h10);
        chk("t3_pre_valid", {63'd0, inst_valid}, 64'd1);

        // Redirect flushes the buffered word at 0x10
        redirect_valid = 1'b1;
        redirect_pc    = 8'h22;
        push_exp(8'h20);
        push_exp(8'h24);
        push_exp(8'h28);
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", {63'd0, inst_valid}, 64'd0);
        chk("t3_addr_aligned", {56'd0, imem_addr}, 64'h20);
        tick();
        chk("t3_first_pc", {56'd0, inst_pc}, 64'h20);
        tick();
        tick();
        chk("t3_pc28", {56'd0, inst_pc}, 64'h28);
        tick();

        // Zero word at 0x2C halts
        chk("t4_halted", {63'd0, halted}, 64'd1);
        chk("t4_no_valid", {63'd0, inst_valid}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_addr_frozen", {56'd0, imem_addr}, 64'h2C);
            chk("t4_still_halted", {63'd0, halted}, 64'd1);
            chk("t4_still_empty", {63'd0, inst_valid}, 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        push_exp(8'h00);
        push_exp(8'h04);
        tick();
        redirect_valid = 1'b0;
        chk("t4_unhalted", {63'd0, halted}, 64'd0);
        chk("t4_addr0", {56'd0, imem_addr}, 64'h00);
        tick();
        chk("t4_resume_pc", {56'd0, inst_pc}, 64'h00);
        tick();
        chk("t4_resume_pc4", {56'd0, inst_pc}, 64'h04);
        tick();
        chk("t4_pc8", {56'd0, inst_pc}, 64'h08);

        // Wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        push_exp(8'hFC);
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr_fc", {56'd0, imem_addr}, 64'hFC);
        tick();
        chk("t5_pc_fc", {56'd0, inst_pc}, 64'hFC);
        chk("t5_inst_fc", {32'd0, inst}, 64'h5A5A_00FC);
        chk("t5_addr_wrap", {56'd0, imem_addr}, 64'h00);
        tick();
        chk("t5_pc_wrapped", {56'd0, inst_pc}, 64'h00);
        chk("t5_valid", {63'd0, inst_valid}, 64'd1);

        // Asynchronous reset mid-cycle while streaming
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {63'd0, inst_valid}, 64'd0);
        chk("t6_async_addr", {56'd0, imem_addr}, 64'h00);
        chk("t6_async_inst_pc", {56'd0, inst_pc}, 64'h00);
        fetch_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_valid", {63'd0, inst_valid}, 64'd0);
            chk("t6_idle_addr", {56'd0, imem_addr}, 64'h00);
        end
        push_exp(8'h00);
        fetch_en = 1'b1;
        tick();
        tick();
        chk("t6_restart_pc", {56'd0, inst_pc}, 64'h00);
        chk("t6_restart_valid", {63'd0, inst_valid}, 64'd1);
        fetch_en = 1'b0;
        tick();
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
